// File: rtl/pu_write_packer.sv
// PU write packer: buffers wide PU result words in a small FIFO and streams them
// out as AXI-width write beats, least-significant slice first, in bursts of a
// requested length. The slice position carries across bursts so a burst may end
// mid-word and the next one resumes where it stopped.
module pu_write_packer #(
  parameter int unsigned OP_WIDTH       = 16,
  parameter int unsigned NUM_PE         = 8,
  parameter int unsigned AXI_DATA_WIDTH = 64,  // must divide OP_WIDTH*NUM_PE
  parameter int unsigned FIFO_DEPTH     = 4,   // power of two, >= 2
  parameter int unsigned BURST_LEN_W    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [OP_WIDTH*NUM_PE-1:0]    write_data,
  input  logic                          write_req,
  output logic                          write_ready,
  input  logic                          start,
  input  logic [BURST_LEN_W-1:0]        burst_len,
  output logic [AXI_DATA_WIDTH-1:0]     wr_data,
  output logic                          wr_valid,
  output logic                          wr_last,
  input  logic                          wr_ready,
  output logic                          burst_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned WordW  = OP_WIDTH * NUM_PE;
  localparam int unsigned Beats  = WordW / AXI_DATA_WIDTH;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned SliceW = (Beats > 1) ? $clog2(Beats) : 1;

  localparam logic [CntW-1:0]   DepthC    = CntW'(FIFO_DEPTH);
  localparam logic [SliceW-1:0] LastSlice = SliceW'(Beats - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  // Storage is viewed as an array of beats so the current slice is a plain index.
  logic [Beats-1:0][AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  state_e                 state_q, state_d;
  logic [BURST_LEN_W-1:0] beats_left_q, beats_left_d;
  logic [SliceW-1:0]      slice_q, slice_d;
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        count_q, count_d;
  logic                   overflow_q;
  logic                   burst_done_q;

  logic push;
  logic pop;
  logic xfer;
  logic last_slice;

  // Handshake decode; everything here depends only on registered state and inputs.
  always_comb begin
    write_ready = (count_q < DepthC);
    wr_valid    = (state_q == StStream) && (count_q != '0);
    wr_last     = wr_valid && (beats_left_q == '0);
    wr_data     = mem_q[rd_ptr_q][slice_q];
    push        = write_req && write_ready;
    xfer        = wr_valid && wr_ready;
    last_slice  = (slice_q == LastSlice);
    pop         = xfer && last_slice;
    burst_done  = burst_done_q;
    overflow    = overflow_q;
    fifo_count  = count_q;
  end

  // Burst FSM next state and beat countdown.
  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StStream;
          beats_left_d = burst_len;
        end
      end
      StStream: begin
        if (xfer) begin
          if (wr_last) begin
            state_d = StIdle;
          end else begin
            beats_left_d = beats_left_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Slice position and FIFO occupancy next state.
  always_comb begin
    slice_d = slice_q;
    count_d = count_q;
    if (xfer) begin
      slice_d = last_slice ? '0 : slice_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards buffered words and any partial burst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      beats_left_q <= '0;
      slice_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      slice_q      <= slice_d;
      count_q      <= count_d;
      burst_done_q <= xfer && wr_last;
      // Pointers wrap naturally since FIFO_DEPTH is a power of two.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (write_req && !write_ready) overflow_q <= 1'b1;
    end
  end

  // Word storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

endmodule

// File: tb/tb_pu_write_packer.sv
// Directed bench for pu_write_packer: expected beats are queued when words are
// pushed and checked in order as the DUT transfers them.
module tb_pu_write_packer;

  localparam int unsigned OpW   = 16;
  localparam int unsigned NPe   = 8;
  localparam int unsigned AxiW  = 64;
  localparam int unsigned Depth = 4;
  localparam int unsigned BlW   = 8;
  localparam int unsigned WordW = OpW * NPe;
  localparam int unsigned Beats = WordW / AxiW;

  logic             clk = 1'b0;
  logic             reset;
  logic [WordW-1:0] write_data;
  logic             write_req;
  logic             write_ready;
  logic             start;
  logic [BlW-1:0]   burst_len;
  logic [AxiW-1:0]  wr_data;
  logic             wr_valid;
  logic             wr_last;
  logic             wr_ready;
  logic             burst_done;
  logic             overflow;
  logic [2:0]       fifo_count;

  pu_write_packer #(
    .OP_WIDTH      (OpW),
    .NUM_PE        (NPe),
    .AXI_DATA_WIDTH(AxiW),
    .FIFO_DEPTH    (Depth),
    .BURST_LEN_W   (BlW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .write_data (write_data),
    .write_req  (write_req),
    .write_ready(write_ready),
    .start      (start),
    .burst_len  (burst_len),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_last    (wr_last),
    .wr_ready   (wr_ready),
    .burst_done (burst_done),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [AxiW-1:0] exp_q[$];
  int              left_m    = 0;
  bit              in_burst  = 0;
  bit              exp_done  = 0;
  bit              stall_prev = 0;
  logic [AxiW-1:0] data_prev = '0;
  int              xfers     = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [WordW-1:0] w);
    for (int k = 0; k < Beats; k++) exp_q.push_back(w[k*AxiW +: AxiW]);
  endtask

  // Present one word for a single cycle; only accepted words enter the scoreboard.
  task automatic push_word(input logic [WordW-1:0] w, input bit accept);
    write_data = w;
    write_req  = 1'b1;
    if (accept) sb_push(w);
    tick();
    write_req  = 1'b0;
  endtask

  task automatic start_burst(input int len);
    start     = 1'b1;
    burst_len = BlW'(len);
    left_m    = len;
    in_burst  = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && in_burst; i++) tick();
    chk(tag, in_burst, 1'b0);
    tick();
    tick();
  endtask

  function automatic logic [WordW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Output monitor: beat order/content, wr_last, burst_done timing, stall stability.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      in_burst   = 1'b0;
      exp_done   = 1'b0;
      stall_prev = 1'b0;
      left_m     = 0;
    end else begin
      chk("burst_done", burst_done, exp_done);
      if (stall_prev) begin
        chk("hold_valid", wr_valid, 1'b1);
        chk("hold_data", wr_data, data_prev);
      end
      exp_done = 1'b0;
      if (wr_valid && wr_ready) begin
        xfers++;
        chk("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("wr_data", wr_data, exp_q.pop_front());
        chk("wr_last", wr_last, left_m == 0);
        if (left_m == 0) begin
          in_burst = 1'b0;
          exp_done = 1'b1;
        end else begin
          left_m--;
        end
      end
      stall_prev = wr_valid && !wr_ready;
      data_prev  = wr_data;
    end
  end

  initial begin
    int x0;
    int rdy_seq[5] = '{0, 1, 0, 0, 1};
    write_data = '0;
    write_req  = 1'b0;
    start      = 1'b0;
    burst_len  = '0;
    wr_ready   = 1'b1;
    reset      = 1'b1;
    #1 reset   = 1'b0;
    #1;
    chk("rst_write_ready", write_ready, 1'b1);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_wr_last", wr_last, 1'b0);
    chk("rst_burst_done", burst_done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_fifo_count", fifo_count, 3'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Single word, two-beat burst, no backpressure.
    push_word(128'h4444_3333_2222_1111_DDDD_CCCC_BBBB_AAAA, 1'b1);
    chk("t1_count", fifo_count, 3'd1);
    x0 = xfers;
    start_burst(1);
    wait_idle("t1_timeout");
    chk("t1_beats", xfers - x0, 2);
    chk("t1_count_end", fifo_count, 3'd0);

    // Same burst shape with wr_ready toggling.
    wr_ready = 1'b0;
    push_word(rnd_word(), 1'b1);
    x0 = xfers;
    start_burst(1);
    for (int i = 0; i < 5; i++) begin
      wr_ready = rdy_seq[i][0];
      tick();
    end
    wr_ready = 1'b1;
    wait_idle("t2_timeout");
    chk("t2_beats", xfers - x0, 2);
    chk("t2_count_end", fifo_count, 3'd0);

    // Fill to full, fifth word dropped, then drain.
    for (int i = 0; i < 5; i++) begin
      write_data = rnd_word();
      write_req  = 1'b1;
      if (i < 4) sb_push(write_data);
      tick();
      if (i == 3) begin
        chk("t3_ready_full", write_ready, 1'b0);
        chk("t3_count_full", fifo_count, 3'd4);
        chk("t3_no_ovf_yet", overflow, 1'b0);
      end
    end
    write_req = 1'b0;
    chk("t3_overflow", overflow, 1'b1);
    chk("t3_count_hold", fifo_count, 3'd4);
    start_burst(7);
    wait_idle("t3_timeout");
    chk("t3_sb_empty", exp_q.size(), 0);
    chk("t3_count_end", fifo_count, 3'd0);
    chk("t3_ovf_sticky", overflow, 1'b1);

    // Burst ending mid-word; the next burst resumes at slice 1.
    push_word(rnd_word(), 1'b1);
    start_burst(0);
    wait_idle("t4a_timeout");
    chk("t4_count_mid", fifo_count, 3'd1);
    start_burst(0);
    wait_idle("t4b_timeout");
    chk("t4_count_end", fifo_count, 3'd0);

    // Push coinciding with the pop of the head word.
    push_word(rnd_word(), 1'b1);
    push_word(rnd_word(), 1'b1);
    chk("t5_count_pre", fifo_count, 3'd2);
    start_burst(1);
    tick();
    write_data = rnd_word();
    write_req  = 1'b1;
    sb_push(write_data);
    tick();
    write_req = 1'b0;
    chk("t5_count_same", fifo_count, 3'd2);
    wait_idle("t5a_timeout");
    start_burst(3);
    wait_idle("t5b_timeout");
    chk("t5_count_end", fifo_count, 3'd0);

    // Reset asserted while beat 1 of a four-beat burst is on the bus.
    push_word(rnd_word(), 1'b1);
    push_word(rnd_word(), 1'b1);
    start_burst(3);
    tick();
    chk("t6_mid_valid", wr_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid", wr_valid, 1'b0);
    chk("t6_rst_last", wr_last, 1'b0);
    chk("t6_rst_done", burst_done, 1'b0);
    chk("t6_rst_ready", write_ready, 1'b1);
    chk("t6_rst_count", fifo_count, 3'd0);
    chk("t6_rst_ovf", overflow, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk("t6_count_after", fifo_count, 3'd0);
    chk("t6_valid_after", wr_valid, 1'b0);

    // First burst after reset starts at slice 0.
    push_word(rnd_word(), 1'b1);
    start_burst(0);
    wait_idle("t7a_timeout");
    start_burst(0);
    wait_idle("t7b_timeout");
    chk("t7_count_end", fifo_count, 3'd0);
    chk("t7_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pu_write_packer.md
PU_WRITE_PACKER -- requirements
Module: pu_write_packer

Interface
REQ-001 Parameter OP_WIDTH, default 16: width of one PE output operand.
REQ-002 Parameter NUM_PE, default 8: number of operands in one PU write word.
REQ-003 Parameter AXI_DATA_WIDTH, default 64: width of one memory-side write beat. OP_WIDTH*NUM_PE SHALL be an integer multiple of AXI_DATA_WIDTH.
REQ-004 Parameter FIFO_DEPTH, default 4: number of PU words buffered; power of two, at least 2.
REQ-005 Parameter BURST_LEN_W, default 8: width of the burst length field.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 write_data  input  OP_WIDTH*NUM_PE  PU output word.
REQ-009 write_req  input  1  PU word valid this cycle.
REQ-010 write_ready  output  1  packer can accept a word this cycle.
REQ-011 start  input  1  single-cycle pulse that begins one burst.
REQ-012 burst_len  input  BURST_LEN_W  beats in the burst minus 1; sampled on start.
REQ-013 wr_data  output  AXI_DATA_WIDTH  memory write beat.
REQ-014 wr_valid  output  1  beat valid.
REQ-015 wr_last  output  1  last beat of the burst.
REQ-016 wr_ready  input  1  memory controller accepts the beat.
REQ-017 burst_done  output  1  one-cycle pulse after the last beat is accepted.
REQ-018 overflow  output  1  sticky flag: a word was dropped.
REQ-019 fifo_count  output  log2(FIFO_DEPTH)+1  number of words held.

Function
REQ-020 write_ready SHALL equal (fifo_count < FIFO_DEPTH). It is a combinational function of registered state only.
REQ-021 A push SHALL occur on write_req && write_ready. The word is written at the clock edge and can appear on wr_data in the next cycle.
REQ-022 A write_req while write_ready=0 SHALL drop the word and set overflow. overflow stays set until reset.
REQ-023 Each word SHALL be split into BEATS = OP_WIDTH*NUM_PE/AXI_DATA_WIDTH beats, least-significant slice first: beat k carries bits [(k+1)*AXI_DATA_WIDTH-1 : k*AXI_DATA_WIDTH].
REQ-024 The FSM SHALL have two states. IDLE goes to STREAM on start, loading beats_left = burst_len. STREAM goes to IDLE on the accepted beat that has wr_last=1. start is ignored in STREAM.
REQ-025 wr_valid SHALL equal (state==STREAM && fifo_count!=0). wr_data SHALL be the current slice of the head word.
REQ-026 Once asserted, wr_valid and wr_data SHALL hold stable until wr_ready=1.
REQ-027 A beat transfers on wr_valid && wr_ready. The slice counter increments on each transfer and wraps to 0 after slice BEATS-1. The head word is popped on that wrap.
REQ-028 wr_last SHALL equal wr_valid && (beats_left==0). beats_left decrements on each transfer that is not the last.
REQ-029 The slice counter SHALL persist across bursts. A burst may end mid-word; the next burst then resumes at the remaining slice.
REQ-030 A push and a pop in the same cycle SHALL leave fifo_count unchanged. A push when full that coincides with a pop is still rejected, because write_ready was 0.
REQ-031 burst_done SHALL pulse in the cycle after the wr_last beat is accepted.
REQ-032 Read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-033 When reset=0, regardless of clk: state=IDLE; pointers, counters and fifo_count are 0; overflow=0; wr_valid=0, wr_last=0, burst_done=0; write_ready=1. wr_data is don't-care.
REQ-034 Reset asserted mid-burst SHALL discard all buffered words and any partial burst. The first start after reset then begins at slice 0.

Verification
REQ-035 Single word: push 0x4444_3333_2222_1111_DDDD_CCCC_BBBB_AAAA, start with burst_len=1, wr_ready held at 1. Required: beat 0xDDDD_CCCC_BBBB_AAAA with wr_last=0; then 0x4444_3333_2222_1111 with wr_last=1; burst_done one cycle later; fifo_count returns to 0.
REQ-036 Backpressure: same burst with wr_ready toggling 0,1,0,0,1. Required: wr_data and wr_valid stable while wr_ready=0, and exactly 2 beats transferred.
REQ-037 Full and overflow: with no start, 5 consecutive write_req. Required: write_ready=0 after the 4th push, fifo_count=4, overflow=1, and the 5th word never emitted.
REQ-038 Mid-word burst split: one word, then start burst_len=0 twice. Required: the first burst emits slice 0 with wr_last=1; the second emits slice 1 with wr_last=1; the word pops only after the second burst.
REQ-039 Simultaneous push/pop: fifo_count=2, push while the final slice of the head is accepted. Required: fifo_count stays 2.
REQ-040 Reset mid-burst: assert reset during beat 1 of a 4-beat burst. Required: all outputs at reset values immediately and asynchronously; fifo_count=0 after release.
